// File: rtl/membus_arb_if.sv
// Per-master request/response bundle for membus_arb.
// The master modport drives the request; the slave modport returns rdy/rdata.
interface membus_arb_if;
    logic        req;
    logic [31:0] adr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        rdy;
    logic [31:0] rdata;

    modport master (
        output req, adr, wdata, wstrb,
        input  rdy, rdata
    );

    modport slave (
        input  req, adr, wdata, wstrb,
        output rdy, rdata
    );
endinterface

// File: rtl/membus_arb.sv
// Two-master (debug m0, CPU m1) to one-slave registered memory bus arbiter.
// Define MEMBUS_ARB_RR_EN for round-robin tie-breaking instead of fixed m0 priority.
module membus_arb #(
    parameter int RD_LATENCY = 1
) (
    input  logic               clk,
    input  logic               reset,
    membus_arb_if.slave        m0,
    membus_arb_if.slave        m1,
    input  logic               m1_en,
    output logic               mem_op,
    output logic [31:0]        mem_adr,
    output logic [31:0]        mem_di,
    output logic [3:0]         mem_wren,
    input  logic [31:0]        mem_do,
    output logic               busy,
    output logic               gnt
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [1:0] CNT_INIT = 2'(RD_LATENCY - 1);

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        gnt_q, gnt_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] di_q, di_d;
    logic        op_q, op_d;
    logic [3:0]  wren_q, wren_d;
    logic        rdy0_q, rdy0_d;
    logic        rdy1_q, rdy1_d;
    logic [31:0] rd0_q, rd0_d;
    logic [31:0] rd1_q, rd1_d;
    logic [31:0] cap;

    logic v0, v1, pick;

    assign v0 = m0.req;
    assign v1 = m1.req & m1_en;

`ifdef MEMBUS_ARB_RR_EN
    logic rr_last_q;

    // Tie goes to whoever was not granted last; reset value favours m0.
    assign pick = (v0 & v1) ? ~rr_last_q : ~v0;

    always_ff @(posedge clk) begin
        if (reset)
            rr_last_q <= 1'b1;
        else if (state_q == IDLE && (v0 | v1))
            rr_last_q <= pick;
    end
`else
    assign pick = ~v0;
`endif

    // Writes return zero so a stale OR-bus value never reaches the master.
    assign cap = (wstrb_q != 4'h0) ? 32'h0 : mem_do;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wstrb_d = wstrb_q;
        gnt_d   = gnt_q;
        adr_d   = adr_q;
        di_d    = di_q;
        op_d    = 1'b0;
        wren_d  = 4'h0;
        rdy0_d  = 1'b0;
        rdy1_d  = 1'b0;
        rd0_d   = rd0_q;
        rd1_d   = rd1_q;
        unique case (state_q)
            IDLE: begin
                if (v0 | v1) begin
                    gnt_d   = pick;
                    adr_d   = pick ? m1.adr : m0.adr;
                    di_d    = pick ? m1.wdata : m0.wdata;
                    wstrb_d = pick ? m1.wstrb : m0.wstrb;
                    wren_d  = pick ? m1.wstrb : m0.wstrb;
                    op_d    = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = CNT_INIT;
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q != 2'd0) begin
                    cnt_d = cnt_q - 2'd1;
                end else begin
                    if (gnt_q) begin
                        rd1_d  = cap;
                        rdy1_d = 1'b1;
                    end else begin
                        rd0_d  = cap;
                        rdy0_d = 1'b1;
                    end
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            wstrb_q <= 4'h0;
            gnt_q   <= 1'b0;
            adr_q   <= 32'h0;
            di_q    <= 32'h0;
            op_q    <= 1'b0;
            wren_q  <= 4'h0;
            rdy0_q  <= 1'b0;
            rdy1_q  <= 1'b0;
            rd0_q   <= 32'h0;
            rd1_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wstrb_q <= wstrb_d;
            gnt_q   <= gnt_d;
            adr_q   <= adr_d;
            di_q    <= di_d;
            op_q    <= op_d;
            wren_q  <= wren_d;
            rdy0_q  <= rdy0_d;
            rdy1_q  <= rdy1_d;
            rd0_q   <= rd0_d;
            rd1_q   <= rd1_d;
        end
    end

    assign mem_op   = op_q;
    assign mem_adr  = adr_q;
    assign mem_di   = di_q;
    assign mem_wren = wren_q;
    assign busy     = (state_q != IDLE);
    assign gnt      = gnt_q;
    assign m0.rdy   = rdy0_q;
    assign m0.rdata = rd0_q;
    assign m1.rdy   = rdy1_q;
    assign m1.rdata = rd1_q;

endmodule

// File: tb/tb_membus_arb.sv
// Directed testbench for membus_arb: vector table plus multi-cycle sequences,
// with one instance at RD_LATENCY=1 and one at RD_LATENCY=3.
module tb_membus_arb;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    membus_arb_if m0_if ();
    membus_arb_if m1_if ();
    membus_arb_if m0_if3 ();
    membus_arb_if m1_if3 ();

    logic        m1_en, m1_en3;
    logic        op1, op3;
    logic [31:0] adr1, adr3, di1, di3, do1, do3;
    logic [3:0]  wren1, wren3;
    logic        busy1, busy3, gnt1, gnt3;

    membus_arb #(.RD_LATENCY(1)) u1 (
        .clk(clk), .reset(reset), .m0(m0_if.slave), .m1(m1_if.slave),
        .m1_en(m1_en), .mem_op(op1), .mem_adr(adr1), .mem_di(di1),
        .mem_wren(wren1), .mem_do(do1), .busy(busy1), .gnt(gnt1)
    );

    membus_arb #(.RD_LATENCY(3)) u3 (
        .clk(clk), .reset(reset), .m0(m0_if3.slave), .m1(m1_if3.slave),
        .m1_en(m1_en3), .mem_op(op3), .mem_adr(adr3), .mem_di(di3),
        .mem_wren(wren3), .mem_do(do3), .busy(busy3), .gnt(gnt3)
    );

    // Slave model: data is on the OR-bus only in the cycle RD_LATENCY after mem_op.
    logic [31:0] sval1, sval3;
    logic [3:0]  opd1, opd3;

    always @(posedge clk) begin
        if (reset) begin
            opd1 <= 4'h0;
            opd3 <= 4'h0;
        end else begin
            opd1 <= {opd1[2:0], op1};
            opd3 <= {opd3[2:0], op3};
        end
    end

    assign do1 = opd1[0] ? sval1 : 32'h0;
    assign do3 = opd3[2] ? sval3 : 32'h0;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctl"}, {24'h0, op1, wren1, busy1, gnt1, m0_if.rdy}, 32'h0);
        chk({tag, "_rdy1"}, {31'h0, m1_if.rdy}, 32'h0);
        chk({tag, "_adr"}, adr1, 32'h0);
        chk({tag, "_di"}, di1, 32'h0);
        chk({tag, "_rd"}, m0_if.rdata | m1_if.rdata, 32'h0);
    endtask

    typedef struct {
        logic        m;
        logic [31:0] adr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] sval;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t tbl [5];
    logic [31:0] exp_rd [2];

    task automatic set_req(input logic m, input logic v);
        if (m) m1_if.req = v;
        else   m0_if.req = v;
    endtask

    // One transaction on u1; caller is at a negedge with the bus idle.
    task automatic do_txn(input vec_t v);
        int  cyc;
        bit  got;
        int  opx;
        if (v.m) begin
            m1_if.adr = v.adr; m1_if.wdata = v.wdata; m1_if.wstrb = v.wstrb;
        end else begin
            m0_if.adr = v.adr; m0_if.wdata = v.wdata; m0_if.wstrb = v.wstrb;
        end
        sval1 = v.sval;
        set_req(v.m, 1'b1);
        @(negedge clk);
        chk("issue_op", {31'h0, op1}, 32'h1);
        chk("issue_adr", adr1, v.adr);
        chk("issue_di", di1, v.wdata);
        chk("issue_wren", {28'h0, wren1}, {28'h0, v.wstrb});
        chk("issue_gnt", {31'h0, gnt1}, {31'h0, v.m});
        cyc = 1; got = 0; opx = 0;
        while (!got && cyc < 12) begin
            @(negedge clk);
            cyc++;
            if (m0_if.rdy | m1_if.rdy) got = 1;
            if (op1 || wren1 != 4'h0) opx++;
        end
        chk("latency", 32'(cyc), 32'd3);
        chk("op_once", 32'(opx), 32'd0);
        chk("rdy_pair", {30'h0, m1_if.rdy, m0_if.rdy}, v.m ? 32'h2 : 32'h1);
        chk("rdata", v.m ? m1_if.rdata : m0_if.rdata, v.exp_rd);
        exp_rd[v.m] = v.exp_rd;
        set_req(v.m, 1'b0);
        @(negedge clk);
        chk("rdy_off", {30'h0, m1_if.rdy, m0_if.rdy}, 32'h0);
        chk("rd_hold0", m0_if.rdata, exp_rd[0]);
        chk("rd_hold1", m1_if.rdata, exp_rd[1]);
    endtask

    initial begin
        int  first_c, second_c, n0, n1;
        logic first_m, second_m;
        int  cyc;
        bit  got;
        bit  seen_op, seen_busy;

        m0_if.req = 0; m0_if.adr = 0; m0_if.wdata = 0; m0_if.wstrb = 0;
        m1_if.req = 0; m1_if.adr = 0; m1_if.wdata = 0; m1_if.wstrb = 0;
        m0_if3.req = 0; m0_if3.adr = 0; m0_if3.wdata = 0; m0_if3.wstrb = 0;
        m1_if3.req = 0; m1_if3.adr = 0; m1_if3.wdata = 0; m1_if3.wstrb = 0;
        m1_en = 1; m1_en3 = 0; sval1 = 0; sval3 = 0;
        exp_rd[0] = 0; exp_rd[1] = 0;

        tbl[0] = '{1'b1, 32'h0002_0004, 32'h0, 4'h0, 32'hCAFE_BABE, 32'hCAFE_BABE};
        tbl[1] = '{1'b0, 32'h0000_0010, 32'h1234_5678, 4'hF, 32'hDEAD_BEEF, 32'h0};
        tbl[2] = '{1'b0, 32'h0000_0003, 32'h0, 4'h0, 32'h0BAD_F00D, 32'h0BAD_F00D};
        tbl[3] = '{1'b1, 32'h0002_0007, 32'hA5A5_A5A5, 4'h4, 32'hFFFF_FFFF, 32'h0};
        tbl[4] = '{1'b0, 32'hFFFF_FFFC, 32'h0, 4'h0, 32'h1122_3344, 32'h1122_3344};

        repeat (3) @(negedge clk);
        chk_zero("reset");
        reset = 0;
        @(negedge clk);
        chk("idle_busy", {31'h0, busy1}, 32'h0);

        for (int i = 0; i < 5; i++) do_txn(tbl[i]);

        // Simultaneous requests; m0 was granted last.
        m0_if.adr = 32'h100; m0_if.wstrb = 0;
        m1_if.adr = 32'h200; m1_if.wstrb = 0;
        sval1 = 32'h5555_AAAA;
        m0_if.req = 1; m1_if.req = 1;
        first_c = 0; second_c = 0; n0 = 0; n1 = 0;
        first_m = 0; second_m = 0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (m0_if.rdy | m1_if.rdy) begin
                if (first_c == 0) begin
                    first_c = c; first_m = m1_if.rdy;
                end else if (second_c == 0) begin
                    second_c = c; second_m = m1_if.rdy;
                end
                if (m0_if.rdy) begin n0++; m0_if.req = 0; end
                if (m1_if.rdy) begin n1++; m1_if.req = 0; end
            end
        end
`ifdef MEMBUS_ARB_RR_EN
        chk("tie_first", {31'h0, first_m}, 32'h1);
        chk("tie_second", {31'h0, second_m}, 32'h0);
`else
        chk("tie_first", {31'h0, first_m}, 32'h0);
        chk("tie_second", {31'h0, second_m}, 32'h1);
`endif
        chk("tie_c1", 32'(first_c), 32'd3);
        chk("tie_gap", 32'(second_c - first_c), 32'd4);
        chk("tie_cnt", {16'(n0), 16'(n1)}, {16'd1, 16'd1});
        chk("tie_rd", m0_if.rdata & m1_if.rdata, 32'h5555_AAAA);

        // m1_en dropping after the grant does not cancel the transaction.
        sval1 = 32'h7777_0001;
        m1_if.adr = 32'h300;
        m1_if.req = 1;
        @(negedge clk);
        m1_en = 0;
        cyc = 1; got = 0;
        while (!got && cyc < 12) begin
            @(negedge clk);
            cyc++;
            if (m1_if.rdy) got = 1;
        end
        chk("en_fall_lat", 32'(cyc), 32'd3);
        chk("en_fall_rd", m1_if.rdata, 32'h7777_0001);

        // m1 requesting while disabled is ignored.
        seen_op = 0; seen_busy = 0;
        repeat (20) begin
            @(negedge clk);
            if (op1) seen_op = 1;
            if (busy1) seen_busy = 1;
        end
        chk("gate_op", {31'h0, seen_op}, 32'h0);
        chk("gate_busy", {31'h0, seen_busy}, 32'h0);
        m1_if.req = 0;
        m1_en = 1;

        // RD_LATENCY=3 instance.
        sval3 = 32'h600D_CAFE;
        m0_if3.adr = 32'h44;
        m0_if3.req = 1;
        cyc = 0; got = 0;
        while (!got && cyc < 15) begin
            @(negedge clk);
            cyc++;
            if (m0_if3.rdy) got = 1;
        end
        chk("lat3", 32'(cyc), 32'd5);
        chk("lat3_rd", m0_if3.rdata, 32'h600D_CAFE);
        m0_if3.req = 0;
        @(negedge clk);

        // Reset in the WAIT cycle aborts with no rdy.
        sval1 = 32'h9999_9999;
        m0_if.adr = 32'h80; m0_if.wstrb = 0;
        m0_if.req = 1;
        @(negedge clk);
        chk("abort_issue", {31'h0, op1}, 32'h1);
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        chk_zero("abort");
        reset = 0;
        m0_if.req = 0;
        got = 0;
        repeat (8) begin
            @(negedge clk);
            if (m0_if.rdy | m1_if.rdy) got = 1;
        end
        chk("abort_no_rdy", {31'h0, got}, 32'h0);
        exp_rd[0] = 0; exp_rd[1] = 0;
        do_txn('{1'b0, 32'h0000_0084, 32'h0, 4'h0, 32'h0F0F_0F0F, 32'h0F0F_0F0F});

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
